lcd_st7920_ctrl: RTL and testbench

LCD_ST7920_CTRL -- requirements
Module: lcd_st7920_ctrl

---
 rtl/lcd_st7920_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_lcd_st7920_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_st7920_ctrl.sv
// lcd_st7920_ctrl: character-mode sequencer for an ST7920 LCD on an 8-bit parallel bus.
// It holds a 64-byte character buffer (4 lines x 16 bytes), runs the power-up command
// sequence, then redraws the buffer after init and on every refresh request.
// Optional feature macro: LCD_AUTO_REFRESH_EN. When defined, it adds the REFRESH_TICKS
// parameter and a periodic refresh request that is raised while the sequencer is idle.
module lcd_st7920_ctrl #(
    parameter int CLK_DIV   = 50,
    parameter int INIT_WAIT = 20,
    parameter int CLR_WAIT  = 8,
    parameter int NUM_LINES = 4
`ifdef LCD_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_TICKS = 10000
`endif
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0] LAST_LINE = 2'(NUM_LINES - 1);

    typedef enum logic [3:0] {
        S_WAIT_PWR,
        S_FUNC1,
        S_FUNC2,
        S_DISP,
        S_CLR,
        S_WAIT_CLR,
        S_ENTRY,
        S_REFRESH,
        S_IDLE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    // DDRAM start address of each display line.
    function automatic logic [7:0] line_addr(input logic [1:0] line);
        logic [7:0] a;
        case (line)
            2'd0:    a = 8'h80;
            2'd1:    a = 8'h90;
            2'd2:    a = 8'h88;
            default: a = 8'h98;
        endcase
        return a;
    endfunction

    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;
    state_t           state_r;
    phase_t           phase_r;
    logic [15:0]      wait_r;
    logic [1:0]       line_r;
    logic [4:0]       col_r;        // 0 = line address command, 1..16 = data column col_r-1
    logic             pending_r;
    logic [7:0]       char_mem_r [0:63];
    logic             auto_req_s;
    logic             advance_s;

    state_t           nx_state_s;
    logic             nx_load_s;
    logic             nx_rs_s;
    logic [7:0]       nx_data_s;
    logic [1:0]       nx_line_s;
    logic [4:0]       nx_col_s;

    assign lcd_rw = 1'b0;
    assign tick_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));

    // Free-running phase tick divider.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Character buffer: single-cycle writes at any time, reset to spaces.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                char_mem_r[i] <= 8'h20;
            end
        end else if (wr_en) begin
            char_mem_r[wr_addr] <= wr_data;
        end
    end

`ifdef LCD_AUTO_REFRESH_EN
    logic [31:0] idle_cnt_r;

    // Count idle ticks; any refresh activity restarts the interval.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 32'd0;
        end else if ((state_r != S_IDLE) || refresh) begin
            idle_cnt_r <= 32'd0;
        end else if (tick_s) begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end
    end

    assign auto_req_s = (state_r == S_IDLE) && ((idle_cnt_r + 32'd1) >= 32'(REFRESH_TICKS));
`else
    assign auto_req_s = 1'b0;
`endif

    // Decide whether this tick ends the current step (wait expired, byte held, or request in idle).
    always_comb begin
        advance_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                S_WAIT_PWR: advance_s = ((wait_r + 16'd1) >= 16'(INIT_WAIT));
                S_WAIT_CLR: advance_s = ((wait_r + 16'd1) >= 16'(CLR_WAIT));
                S_IDLE:     advance_s = pending_r | refresh | auto_req_s;
                S_FUNC1, S_FUNC2, S_DISP, S_CLR, S_ENTRY, S_REFRESH:
                            advance_s = (phase_r == PH_HOLD);
                default:    advance_s = 1'b1;
            endcase
        end else begin
            advance_s = 1'b0;
        end
    end

    // Work out the step that follows the current one and the byte it puts on the bus.
    always_comb begin
        nx_state_s = state_r;
        nx_load_s  = 1'b1;
        nx_rs_s    = 1'b0;
        nx_data_s  = 8'h00;
        nx_line_s  = line_r;
        nx_col_s   = col_r;
        case (state_r)
            S_WAIT_PWR: begin nx_state_s = S_FUNC1; nx_data_s = 8'h30; end
            S_FUNC1:    begin nx_state_s = S_FUNC2; nx_data_s = 8'h30; end
            S_FUNC2:    begin nx_state_s = S_DISP;  nx_data_s = 8'h0C; end
            S_DISP:     begin nx_state_s = S_CLR;   nx_data_s = 8'h01; end
            S_CLR:      begin nx_state_s = S_WAIT_CLR; nx_load_s = 1'b0; end
            S_WAIT_CLR: begin nx_state_s = S_ENTRY; nx_data_s = 8'h06; end
            S_ENTRY, S_IDLE: begin
                nx_state_s = S_REFRESH;
                nx_line_s  = 2'd0;
                nx_col_s   = 5'd0;
                nx_data_s  = line_addr(2'd0);
            end
            S_REFRESH: begin
                if (col_r == 5'd16) begin
                    if (line_r == LAST_LINE) begin
                        nx_state_s = S_IDLE;
                        nx_load_s  = 1'b0;
                    end else begin
                        nx_line_s = line_r + 2'd1;
                        nx_col_s  = 5'd0;
                        nx_data_s = line_addr(line_r + 2'd1);
                    end
                end else begin
                    nx_col_s  = col_r + 5'd1;
                    nx_rs_s   = 1'b1;
                    nx_data_s = char_mem_r[{line_r, col_r[3:0]}];
                end
            end
            default: begin nx_state_s = S_WAIT_PWR; nx_load_s = 1'b0; end
        endcase
    end

    // Main sequencer: step changes, SETUP/STROBE/HOLD phases, registered bus and status.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_WAIT_PWR;
            phase_r   <= PH_SETUP;
            wait_r    <= 16'd0;
            line_r    <= 2'd0;
            col_r     <= 5'd0;
            pending_r <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // A request taken from idle is consumed; any other pulse is remembered once.
            if (advance_s && (state_r == S_IDLE)) begin
                pending_r <= 1'b0;
            end else if (refresh) begin
                pending_r <= 1'b1;
            end

            if (advance_s) begin
                state_r <= nx_state_s;
                line_r  <= nx_line_s;
                col_r   <= nx_col_s;
                wait_r  <= 16'd0;
                phase_r <= PH_SETUP;
                lcd_e   <= 1'b0;
                if (nx_load_s) begin
                    lcd_rs   <= nx_rs_s;
                    lcd_data <= nx_data_s;
                end
                busy <= (nx_state_s != S_IDLE);
                done <= (nx_state_s == S_IDLE);
            end else if (tick_s) begin
                case (state_r)
                    S_WAIT_PWR, S_WAIT_CLR: wait_r <= wait_r + 16'd1;
                    S_FUNC1, S_FUNC2, S_DISP, S_CLR, S_ENTRY, S_REFRESH: begin
                        case (phase_r)
                            PH_SETUP: begin
                                lcd_e   <= 1'b1;
                                phase_r <= PH_STROBE;
                            end
                            PH_STROBE: begin
                                lcd_e   <= 1'b0;
                                phase_r <= PH_HOLD;
                            end
                            default: begin
                                lcd_e   <= 1'b0;
                                phase_r <= PH_HOLD;
                            end
                        endcase
                    end
                    default: lcd_e <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_st7920_ctrl.sv
// Testbench for lcd_st7920_ctrl: decodes the LCD bus into a stream of (rs, byte) strobes and
// compares it with the stream the command/buffer rules say must appear, plus timing checks.
module tb_lcd_st7920_ctrl;

    localparam int CLK_DIV   = 2;
    localparam int INIT_WAIT = 4;
    localparam int CLR_WAIT  = 2;
    localparam int NUM_LINES = 4;
    localparam int RLEN      = NUM_LINES * 17;

    logic       mclk    = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic [7:0] wr_data = 8'd0;
    logic       refresh = 1'b0;
    logic       busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] mdl [64];
    logic [8:0] expq [$];
    logic [8:0] obs [$];

    lcd_st7920_ctrl #(
        .CLK_DIV(CLK_DIV), .INIT_WAIT(INIT_WAIT), .CLR_WAIT(CLR_WAIT), .NUM_LINES(NUM_LINES)
    ) dut (
        .mclk(mclk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh(refresh), .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        expq.push_back({1'b0, 8'h30});
        expq.push_back({1'b0, 8'h30});
        expq.push_back({1'b0, 8'h0C});
        expq.push_back({1'b0, 8'h01});
        expq.push_back({1'b0, 8'h06});
    endtask

    task automatic push_refresh();
        logic [7:0] la [4];
        la = '{8'h80, 8'h90, 8'h88, 8'h98};
        for (int l = 0; l < NUM_LINES; l++) begin
            expq.push_back({1'b0, la[l]});
            for (int c = 0; c < 16; c++) expq.push_back({1'b1, mdl[l*16+c]});
        end
    endtask

    task automatic write_byte(input logic [5:0] a, input logic [7:0] d);
        @(negedge mclk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        mdl[a] = d;
        @(negedge mclk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge mclk);
        refresh = 1'b1;
        @(negedge mclk);
        refresh = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge mclk);
            n++;
        end
        chk(name, done_cnt, target);
    endtask

    // Bus monitor: every cycle, decode strobes and compare with the expected stream.
    logic       prev_e = 1'b0, prev_done = 1'b0;
    logic [8:0] rise_val = 9'd0;
    int         hi_cyc = 0, rel_cyc = 0, last_rise = 0;
    bit         prev_valid = 1'b0, first_seen = 1'b0;
    always @(negedge mclk) begin
        if (!rst_n) begin
            prev_e = 1'b0; prev_done = 1'b0; rel_cyc = 0;
            prev_valid = 1'b0; first_seen = 1'b0;
        end else begin
            rel_cyc++;
            chk("rw_low", lcd_rw, 1'b0);
            if (!busy) prev_valid = 1'b0;
            if (lcd_e && !prev_e) begin
                chk("busy_at_strobe", busy, 1'b1);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("first_rise_not_early", rel_cyc >= INIT_WAIT * CLK_DIV, 1'b1);
                    chk("first_rise_not_late", rel_cyc <= (INIT_WAIT + 2) * CLK_DIV, 1'b1);
                end
                if (prev_valid)
                    chk("rise_spacing", rel_cyc - last_rise,
                        (rise_val == {1'b0, 8'h01}) ? (3 + CLR_WAIT) * CLK_DIV : 3 * CLK_DIV);
                rise_val = {lcd_rs, lcd_data};
                last_rise = rel_cyc;
                prev_valid = 1'b1;
                hi_cyc = 0;
                obs.push_back(rise_val);
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got %0h expected none", rise_val);
                end else begin
                    chk("strobe_byte", rise_val, expq.pop_front());
                end
            end
            if (lcd_e) hi_cyc++;
            if (!lcd_e && prev_e) begin
                chk("e_width", hi_cyc, CLK_DIV);
                chk("hold_stable", {lcd_rs, lcd_data}, rise_val);
            end
            if (done) begin
                chk("done_busy_low", busy, 1'b0);
                chk("done_single_cycle", prev_done, 1'b0);
                if (!prev_done) done_cnt++;
            end
            prev_e = lcd_e;
            prev_done = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        for (int i = 0; i < 64; i++) mdl[i] = 8'h20;

        // Reset values
        repeat (3) @(negedge mclk);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_busy", busy, 1'b1);
        chk("rst_done", done, 1'b0);

        // Init sequence and first full refresh of the blank buffer
        push_init();
        push_refresh();
        rst_n = 1'b1;
        wait_done("init_done", 1, 3000);
        chk("idle_after_init", busy, 1'b0);
        chk("init_queue_empty", expq.size(), 0);
        chk("init_strobe_count", obs.size(), 5 + RLEN);
        if (obs.size() == 5 + RLEN) begin
            chk("lit_func1", obs[0], {1'b0, 8'h30});
            chk("lit_clear", obs[3], {1'b0, 8'h01});
            chk("lit_entry", obs[4], {1'b0, 8'h06});
            chk("lit_addr0", obs[5], {1'b0, 8'h80});
            chk("lit_blank0", obs[6], {1'b1, 8'h20});
            chk("lit_addr1", obs[22], {1'b0, 8'h90});
            chk("lit_blank_last", obs[5 + RLEN - 1], {1'b1, 8'h20});
        end

        // Single write then refresh: column 3 of line 1
        obs.delete();
        write_byte(6'h13, 8'hCE);
        push_refresh();
        base = done_cnt;
        pulse_refresh();
        wait_done("refresh_ce_done", base + 1, 3000);
        chk("ce_strobe_count", obs.size(), RLEN);
        if (obs.size() == RLEN) begin
            chk("lit_ce_addr1", obs[17], {1'b0, 8'h90});
            chk("lit_ce_byte", obs[21], {1'b1, 8'hCE});
            chk("lit_ce_addr2", obs[34], {1'b0, 8'h88});
            chk("lit_ce_addr3", obs[51], {1'b0, 8'h98});
        end

        // Random buffer contents
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) write_byte(6'($urandom_range(0, 63)), 8'($urandom));
            push_refresh();
            base = done_cnt;
            pulse_refresh();
            wait_done("rand_refresh_done", base + 1, 3000);
            chk("rand_queue_empty", expq.size(), 0);
        end

        // Repeated requests mid-refresh collapse into one; mid-refresh write shows next time
        obs.delete();
        push_refresh();
        base = done_cnt;
        pulse_refresh();
        n = 0;
        while (obs.size() < 19 && n < 2000) begin @(negedge mclk); n++; end
        chk("mid_refresh_reached", obs.size() >= 19, 1'b1);
        write_byte(6'($urandom_range(0, 15)), 8'($urandom));
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 20)) @(negedge mclk);
            pulse_refresh();
        end
        push_refresh();
        wait_done("pending_two_done", base + 2, 3000);
        repeat (600) @(negedge mclk);
        chk("no_third_refresh", done_cnt, base + 2);
        chk("pending_queue_empty", expq.size(), 0);

        // Reset during a strobe, then a request during power-up wait
        obs.delete();
        push_refresh();
        pulse_refresh();
        n = 0;
        while (!(lcd_e && obs.size() >= 10) && n < 2000) begin @(negedge mclk); n++; end
        chk("strobe_before_reset", lcd_e, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_e", lcd_e, 1'b0);
        chk("midrst_data", lcd_data, 8'h00);
        chk("midrst_rs", lcd_rs, 1'b0);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_done", done, 1'b0);
        expq.delete();
        for (int i = 0; i < 64; i++) mdl[i] = 8'h20;
        repeat (3) @(negedge mclk);
        push_init();
        push_refresh();
        push_refresh();
        base = done_cnt;
        rst_n = 1'b1;
        repeat (3) @(negedge mclk);
        pulse_refresh();
        wait_done("restart_two_done", base + 2, 4000);
        chk("restart_queue_empty", expq.size(), 0);

        // No spontaneous refresh while idle
        base = done_cnt;
        repeat (1000) @(negedge mclk);
        chk("idle_no_refresh", done_cnt, base);
        chk("idle_busy_low", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
